// File: rtl/traceback_streamer.sv
// Traceback streamer: snapshots a solver's direction grid plus the max-score
// cell, then walks the traceback path toward the origin. It emits one
// direction per accepted beat, end of alignment first.
//
// Output handshake: a beat transfers on a rising edge where out_valid and
// out_ready are both high. Once out_valid is raised it stays high, and
// out_dir/out_last stay unchanged, until that transfer happens. out_ready
// has no effect while out_valid is low.

package datatypes_pkg;
  typedef enum logic [1:0] {
    NONE = 2'd0,
    DIAG = 2'd1,
    UP   = 2'd2,
    LEFT = 2'd3
  } direction_t;
endpackage

module traceback_streamer
  import datatypes_pkg::*;
#(
  parameter int LEN1 = 10,  // sequence 1 length, grid columns
  parameter int LEN2 = 9,   // sequence 2 length, grid rows
  localparam int ROW_W = $clog2(LEN2) + 1,
  localparam int COL_W = $clog2(LEN1) + 1,
  localparam int PL_W  = $clog2(LEN1 + LEN2) + 1
) (
  input  logic              clk,
  input  logic              rst,        // asynchronous, active low
  input  logic              start,
  input  direction_t        grid [LEN2][LEN1],
  input  logic [ROW_W-1:0]  start_row,
  input  logic [COL_W-1:0]  start_col,
  output logic              out_valid,
  input  logic              out_ready,
  output direction_t        out_dir,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [PL_W-1:0]   path_len,
  output logic [1:0]        dbg_state
);

  // Walk coordinates only ever hold in-grid values, so they drop the spare bit.
  localparam int RW = $clog2(LEN2);
  localparam int CW = $clog2(LEN1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WALK = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  direction_t        snap_q [LEN2][LEN1];
  direction_t        snap_d [LEN2][LEN1];
  logic [RW-1:0]     r_q, r_d;
  logic [CW-1:0]     c_q, c_d;
  logic [PL_W-1:0]   plen_q, plen_d;

  logic              start_in_range;
  direction_t        start_cell;
  direction_t        cur_dir;
  direction_t        next_dir;
  logic              step_ok;
  logic              is_last;
  logic [RW-1:0]     nr;
  logic [CW-1:0]     nc;
  logic              fire;

  // Validate the requested start cell before anything is captured.
  always_comb begin
    start_in_range = (start_row < ROW_W'(LEN2)) && (start_col < COL_W'(LEN1));
    start_cell     = NONE;
    if (start_in_range) begin
      start_cell = grid[start_row[RW-1:0]][start_col[CW-1:0]];
    end
  end

  // Lookahead: the next coordinate and whether the current beat ends the path.
  // Zero checks happen before any decrement, so coordinates never wrap.
  always_comb begin
    cur_dir  = snap_q[r_q][c_q];
    nr       = r_q;
    nc       = c_q;
    step_ok  = 1'b0;
    next_dir = NONE;
    case (cur_dir)
      DIAG: begin
        step_ok = (r_q != '0) && (c_q != '0);
        if (step_ok) begin
          nr = r_q - 1'b1;
          nc = c_q - 1'b1;
        end
      end
      UP: begin
        step_ok = (r_q != '0);
        if (step_ok) nr = r_q - 1'b1;
      end
      LEFT: begin
        step_ok = (c_q != '0);
        if (step_ok) nc = c_q - 1'b1;
      end
      default: step_ok = 1'b0;
    endcase
    if (step_ok) next_dir = snap_q[nr][nc];
    is_last = !step_ok || (next_dir == NONE);
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (!start_in_range || (start_cell == NONE)) state_d = S_FIN;
          else                                        state_d = S_WALK;
        end
      end
      S_WALK: begin
        if (out_ready && is_last) state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from state and the snapshot.
  always_comb begin
    out_valid = (state_q == S_WALK);
    out_dir   = (state_q == S_WALK) ? cur_dir : NONE;
    out_last  = (state_q == S_WALK) && is_last;
    busy      = (state_q == S_WALK);
    done      = (state_q == S_FIN);
    path_len  = plen_q;
    dbg_state = state_q;
  end

  assign fire = out_valid && out_ready;

  // Datapath next values: capture on accepted start, advance on each handshake.
  always_comb begin
    snap_d = snap_q;
    r_d    = r_q;
    c_d    = c_q;
    plen_d = plen_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          snap_d = grid;
          plen_d = '0;
          r_d    = '0;
          c_d    = '0;
          if (start_in_range) begin
            r_d = start_row[RW-1:0];
            c_d = start_col[CW-1:0];
          end
        end
      end
      S_WALK: begin
        if (fire) begin
          plen_d = plen_q + 1'b1;
          r_d    = nr;
          c_d    = nc;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset clears the snapshot to NONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LEN2; i++) begin
        for (int j = 0; j < LEN1; j++) begin
          snap_q[i][j] <= NONE;
        end
      end
      r_q    <= '0;
      c_q    <= '0;
      plen_q <= '0;
    end else begin
      snap_q <= snap_d;
      r_q    <= r_d;
      c_q    <= c_d;
      plen_q <= plen_d;
    end
  end

endmodule

// File: tb/tb_traceback_streamer.sv
// Randomised bench for traceback_streamer. The reference model walks the
// grid geometrically and queues expected {last, dir} beats and path lengths;
// a negedge monitor checks every presented beat and every done pulse.
module tb_traceback_streamer;
  import datatypes_pkg::*;

  localparam int LEN1 = 10;
  localparam int LEN2 = 9;

  logic        clk;
  logic        rst;
  logic        start;
  direction_t  g [LEN2][LEN1];
  logic [4:0]  start_row;
  logic [4:0]  start_col;
  logic        out_valid;
  logic        out_ready;
  direction_t  out_dir;
  logic        out_last;
  logic        busy;
  logic        done;
  logic [5:0]  path_len;
  logic [1:0]  dbg_state;

  logic [2:0]  exp_q[$];
  int          plen_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          rdy_mode = 0;

  traceback_streamer #(.LEN1(LEN1), .LEN2(LEN2)) dut (
    .clk(clk), .rst(rst), .start(start), .grid(g),
    .start_row(start_row), .start_col(start_col),
    .out_valid(out_valid), .out_ready(out_ready), .out_dir(out_dir),
    .out_last(out_last), .busy(busy), .done(done), .path_len(path_len),
    .dbg_state(dbg_state)
  );

  // Clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, act=running req=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: act=%0h req=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Ready generator: 0 = always ready, 1 = random, 2 = pattern 1,0,0,1,0,1.
  initial begin
    logic [5:0] pat;
    int idx;
    int prev_mode;
    pat = 6'b101001;
    idx = 0;
    prev_mode = -1;
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode != prev_mode) idx = 0;
      prev_mode = rdy_mode;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: begin
          out_ready = pat[idx];
          idx = (idx + 1) % 6;
        end
      endcase
    end
  end

  // Reference model: follow directions from the start cell until a NONE cell
  // or a step that would leave the grid.
  task automatic push_expected(input int sr, input int sc);
    direction_t path[$];
    int r, c, dr, dc, guard;
    bit stop;
    r = sr; c = sc; stop = 0; guard = 0;
    if (sr < LEN2 && sc < LEN1) begin
      while (!stop && guard < 100) begin
        guard++;
        if (g[r][c] == NONE) stop = 1;
        else begin
          path.push_back(g[r][c]);
          dr = (g[r][c] == DIAG || g[r][c] == UP) ? 1 : 0;
          dc = (g[r][c] == DIAG || g[r][c] == LEFT) ? 1 : 0;
          if (r < dr || c < dc) stop = 1;
          else begin
            r = r - dr;
            c = c - dc;
          end
        end
      end
    end
    for (int i = 0; i < path.size(); i++) begin
      exp_q.push_back({(i == path.size() - 1) ? 1'b1 : 1'b0, 2'(path[i])});
    end
    plen_q.push_back(path.size());
  endtask

  task automatic clear_grid();
    for (int i = 0; i < LEN2; i++)
      for (int j = 0; j < LEN1; j++)
        g[i][j] = NONE;
  endtask

  task automatic random_grid();
    for (int i = 0; i < LEN2; i++)
      for (int j = 0; j < LEN1; j++)
        g[i][j] = direction_t'($urandom_range(0, 3));
  endtask

  task automatic mixed_grid();
    clear_grid();
    g[4][5] = LEFT;
    g[4][4] = UP;
    g[3][4] = DIAG;
    g[2][3] = NONE;
  endtask

  // Pulse start for one cycle from IDLE; scramble inputs afterwards.
  task automatic issue(input int sr, input int sc);
    @(posedge clk);
    #1;
    start_row = sr[4:0];
    start_col = sc[4:0];
    start = 1'b1;
    push_expected(sr, sc);
    @(posedge clk);
    #1;
    start = 1'b0;
    random_grid();
    start_row = 5'($urandom_range(0, 31));
    start_col = 5'($urandom_range(0, 31));
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_done: act=no_done req=done within 200 cycles");
    end
    @(posedge clk);
  endtask

  // Monitor: check presented beats, stall hold, first-beat latency and done.
  initial begin
    bit prev_last_fire;
    bit prev_start_idle;
    bit prev_stall;
    logic [2:0] prev_beat;
    int pl;
    prev_last_fire = 0; prev_start_idle = 0; prev_stall = 0; prev_beat = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_last_fire = 0; prev_start_idle = 0; prev_stall = 0;
      end else begin
        if (prev_start_idle && plen_q.size() > 0)
          check("first_beat_latency", 32'(out_valid), 32'(plen_q[0] != 0));
        if (prev_stall)
          check("stall_hold", {29'd0, out_valid, out_last, 2'(out_dir)} , {29'd0, 1'b1, prev_beat});
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_beat: act=%0h req=none", {out_last, 2'(out_dir)});
          end else begin
            check("beat", 32'({out_last, 2'(out_dir)}), 32'(exp_q[0]));
            if (out_ready) void'(exp_q.pop_front());
          end
        end
        if (done) begin
          if (plen_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: act=done req=no_done at %0t", $time);
          end else begin
            pl = plen_q.pop_front();
            check("path_len", 32'(path_len), 32'(pl));
            check("done_timing", 32'(prev_last_fire || prev_start_idle), 32'd1);
            check("busy_in_fin", 32'(busy), 32'd0);
            check("beats_left", 32'(exp_q.size()), 32'd0);
          end
        end
        prev_last_fire  = out_valid && out_ready && out_last;
        prev_start_idle = start && !busy && !done;
        prev_stall      = out_valid && !out_ready;
        prev_beat       = {out_last, 2'(out_dir)};
      end
    end
  end

  // Stimulus sequence.
  initial begin
    int sr, sc;
    rst = 1'b0;
    start = 1'b0;
    start_row = '0;
    start_col = '0;
    clear_grid();
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_dir", 32'(out_dir), 32'(NONE));
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_path_len", 32'(path_len), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Straight diagonal.
    rdy_mode = 0;
    clear_grid();
    g[0][0] = DIAG; g[1][1] = DIAG; g[2][2] = DIAG;
    issue(2, 2);
    wait_done();

    // Mixed path, then the same path under backpressure.
    mixed_grid();
    issue(4, 5);
    wait_done();
    rdy_mode = 2;
    mixed_grid();
    issue(4, 5);
    wait_done();

    // Empty start cell and out-of-range starts.
    rdy_mode = 0;
    clear_grid();
    issue(3, 3);
    wait_done();
    random_grid();
    issue(9, 0);
    wait_done();
    random_grid();
    issue(0, 10);
    wait_done();

    // Edge walk along row 0 with a start pulse mid-walk that must be ignored.
    random_grid();
    for (int j = 0; j < LEN1; j++) g[0][j] = LEFT;
    issue(0, 9);
    repeat (3) @(posedge clk);
    #1;
    start_row = 5'd2;
    start_col = 5'd2;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done();

    // Async reset during beat 2.
    mixed_grid();
    @(posedge clk);
    #1;
    start_row = 5'd4; start_col = 5'd5; start = 1'b1;
    push_expected(4, 5);
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_path_len", 32'(path_len), 32'd0);
    exp_q.delete();
    plen_q.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (4) @(posedge clk);
    mixed_grid();
    issue(4, 5);
    wait_done();

    // Random grids, random starts, random backpressure.
    rdy_mode = 1;
    for (int k = 0; k < 30; k++) begin
      random_grid();
      sr = $urandom_range(0, 8);
      sc = $urandom_range(0, 9);
      if ($urandom_range(0, 9) == 0) sr = 9;
      if ($urandom_range(0, 9) == 0) sc = 10;
      issue(sr, sc);
      wait_done();
    end

    repeat (5) @(posedge clk);
    check("drain_beats", 32'(exp_q.size()), 32'd0);
    check("drain_dones", 32'(plen_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
